vector_load_assembler: RTL and testbench

Packs a stream of 32-bit lane words into one 256-bit vector and writes it into the vector register file through its write port (WE3/A3/WD3). It sits between the load/memory response path and `Register_File`, and is the producer for the register file's write port. A request names a destination register. The block then collects exactly REG_WIDTH/LANE_WIDTH lanes over a valid/ready handshake and issues a single-cycle write.

---
 rtl/vector_load_assembler.sv | 132 +++++++++++++
 tb/tb_vector_load_assembler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_load_assembler.sv
// Collects REG_WIDTH/LANE_WIDTH lane words into one vector and issues a single-cycle register file write.
// Optional macro VLA_X0_GUARD_EN: requests for register 0 complete normally but never raise WE3.
module vector_load_assembler #(
  parameter int REG_WIDTH  = 256,
  parameter int LANE_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            dest_addr,
  input  logic                  abort,
  output logic                  idle,
  input  logic                  in_valid,
  input  logic [LANE_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  WE3,
  output logic [4:0]            A3,
  output logic [REG_WIDTH-1:0]  WD3,
  output logic                  done,
  output logic [1:0]            fsm_state
);

  localparam int NLANES = REG_WIDTH / LANE_WIDTH;
  localparam int CW     = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NLANES - 1);

  generate
    if ((REG_WIDTH % LANE_WIDTH) != 0 || NUM_REGS > 32) begin : g_bad_cfg
      $error("vector_load_assembler: unsupported REG_WIDTH/LANE_WIDTH/NUM_REGS");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [REG_WIDTH-1:0]  vec;
  logic [REG_WIDTH-1:0]  next_vec;
  logic                  wr_allow;

  // Handshake: a lane is consumed on a rising edge where in_valid and in_ready are both high;
  // in_ready is a registered flag that is high exactly while the FSM sits in COLLECT.

  assign fsm_state = state;

`ifdef VLA_X0_GUARD_EN
  assign wr_allow = (A3 != 5'd0);
`else
  assign wr_allow = 1'b1;
`endif

  always_comb begin
    next_vec = vec;
    for (int i = 0; i < NLANES; i++) begin
      if (cnt == CW'(i)) next_vec[i*LANE_WIDTH +: LANE_WIDTH] = in_data;
    end
  end

  // vec is the working assembly register; WD3 only changes when a full vector completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      vec      <= '0;
      A3       <= 5'd0;
      WD3      <= '0;
      WE3      <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
      idle     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_COLLECT;
            A3       <= dest_addr;
            vec      <= '0;
            cnt      <= '0;
            in_ready <= 1'b1;
            idle     <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (abort) begin
            state    <= S_IDLE;
            cnt      <= '0;
            in_ready <= 1'b0;
            idle     <= 1'b1;
          end else if (in_valid) begin
            vec <= next_vec;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state    <= S_WRITE;
              WD3      <= next_vec;
              WE3      <= wr_allow;
              done     <= 1'b1;
              in_ready <= 1'b0;
              idle     <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          WE3  <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state    <= S_COLLECT;
            A3       <= dest_addr;
            vec      <= '0;
            cnt      <= '0;
            in_ready <= 1'b1;
            idle     <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          WE3      <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b0;
          idle     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_assembler.sv
// Directed bench for vector_load_assembler: a register file model captures writes and a queue holds expected vectors.
module tb_vector_load_assembler;

  logic         clk;
  logic         rst;
  logic         start;
  logic [4:0]   dest_addr;
  logic         abort;
  logic         idle;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic         WE3;
  logic [4:0]   A3;
  logic [255:0] WD3;
  logic         done;
  logic [1:0]   fsm_state;

  int total = 0;
  int bad   = 0;
  int we_count = 0;

  logic [255:0] exp_q[$];
  logic [255:0] exp_v;
  logic [255:0] rf [32];
  logic [31:0]  basic_lanes [8];
  logic [31:0]  r5_lanes [8];

  localparam logic [255:0] BASIC_VEC =
    256'hDEADBEEF_00000001_00000002_00000003_00000004_00000005_00000006_00000007;
  localparam logic [255:0] R5_VEC =
    256'h50000007_50000006_50000005_50000004_50000003_50000002_50000001_50000000;

  vector_load_assembler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dest_addr (dest_addr),
    .abort     (abort),
    .idle      (idle),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model plus scoreboard; WE3 is registered so the falling edge sees a stable write.
  always @(negedge clk) begin
    if (rst === 1'b1 && WE3 === 1'b1) begin
      we_count++;
      rf[A3] = WD3;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write A3=%0d WD3=%h", A3, WD3);
      end else begin
        exp_v = exp_q.pop_front();
        if (WD3 !== exp_v) begin
          bad++;
          $display("FAIL scoreboard_wd3 got=%h exp=%h", WD3, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [4:0] addr);
    start = 1'b1;
    dest_addr = addr;
    step();
    start = 1'b0;
  endtask

  task automatic send_lanes(input logic [31:0] lanes [8], input int stall_a, input int stall_b,
                            output int n);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = lanes[i];
      step();
      n++;
      if (i == stall_a || i == stall_b) begin
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        repeat (2) step();
        n += 2;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    int g;
    g = 0;
    while (done !== 1'b1 && g < 4) begin
      step();
      n++;
      g++;
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0;
    #12;
    total++; if (WE3 !== 1'b0) begin bad++; $display("FAIL rst_we3 got=%b exp=0", WE3); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b exp=1", idle); end
    total++; if (A3 !== 5'd0) begin bad++; $display("FAIL rst_a3 got=%0d exp=0", A3); end
    total++; if (WD3 !== 256'd0) begin bad++; $display("FAIL rst_wd3 got=%h exp=0", WD3); end
    total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", fsm_state); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic_write();
    int n;
    int w0;
    exp_q.push_back(BASIC_VEC);
    w0 = we_count;
    start_req(5'd3);
    total++; if (in_ready !== 1'b1 || idle !== 1'b0) begin bad++; $display("FAIL basic_collect in_ready=%b idle=%b exp=1/0", in_ready, idle); end
    total++; if (A3 !== 5'd3) begin bad++; $display("FAIL basic_a3_latch got=%0d exp=3", A3); end
    send_lanes(basic_lanes, -1, -1, n);
    n += 1;
    wait_done(n);
    total++; if (n != 9) begin bad++; $display("FAIL basic_latency got=%0d exp=9", n); end
    total++; if (WE3 !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL basic_we3_done got=%b/%b exp=1/1", WE3, done); end
    total++; if (WD3 !== BASIC_VEC) begin bad++; $display("FAIL basic_wd3 got=%h exp=%h", WD3, BASIC_VEC); end
    total++; if (idle !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL basic_write_flags idle=%b in_ready=%b exp=1/0", idle, in_ready); end
    step();
    total++; if (WE3 !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL basic_pulse_end got=%b/%b exp=0/0", WE3, done); end
    total++; if (rf[3] !== BASIC_VEC) begin bad++; $display("FAIL basic_rf3 got=%h exp=%h", rf[3], BASIC_VEC); end
    total++; if (we_count != w0 + 1) begin bad++; $display("FAIL basic_write_count got=%0d exp=%0d", we_count - w0, 1); end
  endtask

  task automatic test_stalled();
    int n;
    exp_q.push_back(BASIC_VEC);
    start_req(5'd4);
    send_lanes(basic_lanes, 2, 5, n);
    n += 1;
    wait_done(n);
    total++; if (n != 13) begin bad++; $display("FAIL stall_latency got=%0d exp=13", n); end
    total++; if (WE3 !== 1'b1 || A3 !== 5'd4) begin bad++; $display("FAIL stall_we3_a3 got=%b/%0d exp=1/4", WE3, A3); end
    total++; if (WD3 !== BASIC_VEC) begin bad++; $display("FAIL stall_wd3 got=%h exp=%h", WD3, BASIC_VEC); end
    step();
    total++; if (rf[4] !== BASIC_VEC) begin bad++; $display("FAIL stall_rf4 got=%h exp=%h", rf[4], BASIC_VEC); end
  endtask

  task automatic test_back_to_back();
    int n;
    rf[3] = '0;
    rf[5] = '0;
    exp_q.push_back(BASIC_VEC);
    exp_q.push_back(R5_VEC);
    start_req(5'd3);
    send_lanes(basic_lanes, -1, -1, n);
    total++; if (WE3 !== 1'b1 || A3 !== 5'd3) begin bad++; $display("FAIL b2b_first_write got=%b/%0d exp=1/3", WE3, A3); end
    start_req(5'd5);
    total++; if (in_ready !== 1'b1 || fsm_state !== 2'd1) begin bad++; $display("FAIL b2b_no_bubble in_ready=%b state=%0d exp=1/1", in_ready, fsm_state); end
    total++; if (A3 !== 5'd5) begin bad++; $display("FAIL b2b_a3_latch got=%0d exp=5", A3); end
    total++; if (rf[3] !== BASIC_VEC) begin bad++; $display("FAIL b2b_rf3 got=%h exp=%h", rf[3], BASIC_VEC); end
    send_lanes(r5_lanes, -1, -1, n);
    total++; if (WE3 !== 1'b1 || WD3 !== R5_VEC) begin bad++; $display("FAIL b2b_second_wd3 we=%b got=%h exp=%h", WE3, WD3, R5_VEC); end
    step();
    total++; if (rf[5] !== R5_VEC) begin bad++; $display("FAIL b2b_rf5 got=%h exp=%h", rf[5], R5_VEC); end
  endtask

  task automatic test_abort();
    int n;
    int w0;
    rf[6] = 256'h1234_5678;
    w0 = we_count;
    start_req(5'd6);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = basic_lanes[i];
      step();
    end
    abort    = 1'b1;
    in_data  = basic_lanes[4];
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    total++; if (idle !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL abort_idle idle=%b in_ready=%b exp=1/0", idle, in_ready); end
    total++; if (WE3 !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_no_write got=%b/%b exp=0/0", WE3, done); end
    repeat (2) step();
    total++; if (we_count != w0) begin bad++; $display("FAIL abort_write_count got=%0d exp=0", we_count - w0); end
    total++; if (rf[6] !== 256'h1234_5678) begin bad++; $display("FAIL abort_rf6_kept got=%h exp=12345678", rf[6]); end
    exp_q.push_back(BASIC_VEC);
    start_req(5'd6);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_restart in_ready=%b exp=1", in_ready); end
    send_lanes(basic_lanes, -1, -1, n);
    n += 1;
    wait_done(n);
    total++; if (n != 9 || WD3 !== BASIC_VEC) begin bad++; $display("FAIL abort_fresh_vector lat=%0d wd3=%h exp=9 %h", n, WD3, BASIC_VEC); end
    step();
    total++; if (rf[6] !== BASIC_VEC) begin bad++; $display("FAIL abort_rf6_new got=%h exp=%h", rf[6], BASIC_VEC); end
  endtask

  task automatic test_async_reset();
    int w0;
    w0 = we_count;
    start_req(5'd7);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = basic_lanes[i];
      step();
    end
    #2;
    rst = 1'b0;
    #1;
    total++; if (fsm_state !== 2'd0 || idle !== 1'b1) begin bad++; $display("FAIL arst_state state=%0d idle=%b exp=0/1", fsm_state, idle); end
    total++; if (in_ready !== 1'b0 || WE3 !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL arst_flags rdy=%b we=%b done=%b exp=0/0/0", in_ready, WE3, done); end
    total++; if (A3 !== 5'd0 || WD3 !== 256'd0) begin bad++; $display("FAIL arst_regs a3=%0d wd3=%h exp=0/0", A3, WD3); end
    repeat (5) step();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    total++; if (we_count != w0 || idle !== 1'b1) begin bad++; $display("FAIL arst_no_write writes=%0d idle=%b exp=0/1", we_count - w0, idle); end
  endtask

  task automatic test_reg0();
    int n;
    rf[0] = 256'hAAAA;
`ifndef VLA_X0_GUARD_EN
    exp_q.push_back(BASIC_VEC);
`endif
    start_req(5'd0);
    send_lanes(basic_lanes, -1, -1, n);
    n += 1;
    wait_done(n);
    total++; if (n != 9 || done !== 1'b1) begin bad++; $display("FAIL reg0_done lat=%0d done=%b exp=9/1", n, done); end
`ifdef VLA_X0_GUARD_EN
    total++; if (WE3 !== 1'b0) begin bad++; $display("FAIL reg0_guard_we3 got=%b exp=0", WE3); end
    step();
    total++; if (rf[0] !== 256'hAAAA) begin bad++; $display("FAIL reg0_guard_rf0 got=%h exp=aaaa", rf[0]); end
`else
    total++; if (WE3 !== 1'b1 || A3 !== 5'd0) begin bad++; $display("FAIL reg0_write we=%b a3=%0d exp=1/0", WE3, A3); end
    step();
    total++; if (rf[0] !== BASIC_VEC) begin bad++; $display("FAIL reg0_rf0 got=%h exp=%h", rf[0], BASIC_VEC); end
`endif
  endtask

  initial begin
    start     = 1'b0;
    dest_addr = 5'd0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < 7; i++) basic_lanes[i] = 32'(7 - i);
    basic_lanes[7] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) r5_lanes[i] = 32'h5000_0000 + 32'(i);

    test_reset();
    test_basic_write();
    test_stalled();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_reg0();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
